mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide sequencer for the execute stage; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU as multi-cycle operations. MTHI and MTLO write in a single cycle.
- Stalls the pipeline while an operation is in flight. Aborts cleanly on an exception flush.
- MFHI and MFLO read the hi/lo outputs directly.

Parameters:
- MUL_LAT, default 2: cycles spent in state MUL (1..8). The product is computed combinationally from the captured operands and committed at the end of the last MUL cycle.
- DIV_ITER, default 32: restoring-division iterations, one quotient bit per cycle.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- valid  in  1  execute-stage instruction valid
- op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- a  in  32  rs operand; also the MTHI/MTLO source
- b  in  32  rt operand
- flush  in  1  exception/ERET flush; kills any in-flight operation
- stall  out  1  combinational; holds the pipeline
- busy  out  1  registered; high in MUL or DIV
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, counter=0, operand/remainder/quotient registers=0. stall=0 while in reset.
- States are IDLE, MUL, DIV and DONE.
- IDLE:
  - valid & op in {1,2}: capture a and b, counter=MUL_LAT-1, go to MUL.
  - valid & op in {3,4} & b!=0: capture |a| and |b| (signed ops) or a and b (unsigned ops), record sign flags, counter=DIV_ITER-1, go to DIV.
  - valid & op in {3,4} & b==0: no iteration. Next edge: hi=a, lo=32'hFFFF_FFFF, go to DONE.
  - valid & op=5: hi=a at the edge; stays in IDLE; stall=0. op=6 writes lo the same way.
- stall = (IDLE & valid & op in {1..4} & !flush) | MUL | DIV. stall is low in DONE.
- MUL:
  - Counter decrements each cycle.
  - At counter==0: {hi,lo} = signed (op 1) or unsigned (op 2) 64-bit product of the captured operands; go to DONE.
- DIV:
  - Each cycle: shift remainder:quotient left by 1. If the remainder is >= the divisor, subtract and set quotient bit 0.
  - After the DIV_ITER-th iteration apply signs: the quotient is negated if the sign flags differ; the remainder takes the dividend's sign.
  - Write hi=remainder, lo=quotient; go to DONE.
  - 0x8000_0000 / 0xFFFF_FFFF (signed) gives lo=0x8000_0000, hi=0.
- DONE:
  - One cycle; stall=0, so the held instruction retires with the new hi/lo visible.
  - The still-asserted valid/op is ignored. Return to IDLE unconditionally.
- Latency, measured from the accept cycle T:
  - MULT: stall high for 1+MUL_LAT cycles; hi/lo updated at the end of cycle T+MUL_LAT; DONE at T+MUL_LAT+1.
  - DIV: stall high for 1+DIV_ITER cycles (33 by default); DONE at T+33.
- Flush:
  - Any state: next state is IDLE, counters clear, and hi/lo are not written on that edge.
  - Flush in IDLE together with MTHI/MTLO suppresses the write.
  - Flush together with a mul/div request: the request is not accepted and stall=0.
- Async reset mid-operation: immediate return to the reset values; the partial result is discarded.
- Widths: products are 64-bit, computed with sign- or zero-extension according to op. All subtracts are 33-bit to detect the borrow.

Test Plan:
- Reset, then valid, op=5, a=0x1234_5678 -> next cycle hi=0x1234_5678, lo=0, stall never high. Then op=6, a=0xDEAD_BEEF -> lo=0xDEAD_BEEF.
- MULT with a=0xFFFF_FFFE (-2), b=3, MUL_LAT=2 -> stall high for 3 cycles, then DONE with hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV with a=-7 (0xFFFF_FFF9), b=2 -> stall high for exactly 33 cycles, lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIV with a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0. DIVU with a=5, b=0 -> DONE the cycle after accept, hi=5, lo=0xFFFF_FFFF.
- DIVU started with hi=lo=0x11, flush on iteration 10 -> next cycle state=IDLE, stall=0, busy=0, hi=lo=0x11. Flush coincident with MTHI -> hi unchanged.
- In DONE, valid/op=DIV still held -> no restart, stall=0; a new DIVU in the following cycle is accepted normally. Assert rst mid-MULT -> hi=lo=0 and busy=0 immediately.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl - multiply/divide sequencer for the execute stage.
//
// Owns the architectural HI/LO registers. MULT/MULTU take MUL_LAT cycles in
// state MUL, DIV/DIVU run a restoring divider for DIV_ITER cycles in state DIV,
// and both finish with a single DONE cycle where stall drops so the held
// instruction retires with the new HI/LO visible. MTHI/MTLO write in one cycle.
// A flush returns to IDLE from any state without touching HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   valid  execute-stage instruction valid
//   op     0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   a      rs operand (also MTHI/MTLO source)
//   b      rt operand
//   flush  exception/ERET flush, kills any in-flight operation
//   stall  combinational pipeline hold
//   busy   registered, high while in MUL or DIV
//   hi/lo  architectural HI and LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CMAX = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   opa_reg;        // multiplicand
    logic [31:0]   opb_reg;        // multiplier / divisor magnitude
    logic [31:0]   rem_reg;
    logic [31:0]   quo_reg;        // holds the dividend, shifted out as quotient bits shift in
    logic [31:0]   hi_reg;
    logic [31:0]   lo_reg;
    logic          mul_signed_reg;
    logic          neg_q_reg;
    logic          neg_r_reg;
    logic          busy_reg;

    // ---------------- request decode ----------------
    logic is_mul;
    logic is_div;
    logic op_signed;
    logic a_neg;
    logic b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    assign is_mul    = valid && (op == 3'd1 || op == 3'd2);
    assign is_div    = valid && (op == 3'd3 || op == 3'd4);
    assign op_signed = (op == 3'd1) || (op == 3'd3);
    assign a_neg     = op_signed && a[31];
    assign b_neg     = op_signed && b[31];
    // |0x8000_0000| stays 0x8000_0000, which is the correct unsigned magnitude.
    assign a_abs     = a_neg ? (32'd0 - a) : a;
    assign b_abs     = b_neg ? (32'd0 - b) : b;

    // ---------------- multiplier ----------------
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    assign ext_a   = mul_signed_reg ? {{32{opa_reg[31]}}, opa_reg} : {32'd0, opa_reg};
    assign ext_b   = mul_signed_reg ? {{32{opb_reg[31]}}, opb_reg} : {32'd0, opb_reg};
    // Low 64 bits of the extended product are exact for both signednesses.
    assign product = ext_a * ext_b;

    // ---------------- restoring divider step ----------------
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        no_borrow;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] rem_fin;
    logic [31:0] quo_fin;

    // The shifted remainder can exceed 32 bits when the divisor is large,
    // so the compare/subtract is done at 33 bits and bit 32 is the borrow.
    assign rem_shift = {rem_reg, quo_reg[31]};
    assign diff      = rem_shift - {1'b0, opb_reg};
    assign no_borrow = ~diff[32];
    assign rem_step  = no_borrow ? diff[31:0] : rem_shift[31:0];
    assign quo_step  = {quo_reg[30:0], no_borrow};
    assign quo_fin   = neg_q_reg ? (32'd0 - quo_step) : quo_step;
    assign rem_fin   = neg_r_reg ? (32'd0 - rem_step) : rem_step;

    // ---------------- outputs ----------------
    assign stall = !rst && (((state_reg == IDLE) && (is_mul || is_div) && !flush) ||
                            (state_reg == MUL) || (state_reg == DIV));
    assign busy  = busy_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            mul_signed_reg <= 1'b0;
            neg_q_reg      <= 1'b0;
            neg_r_reg      <= 1'b0;
            busy_reg       <= 1'b0;
        end else if (flush) begin
            // Abort: partial results are dropped and HI/LO are left alone.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_mul) begin
                        opa_reg        <= a;
                        opb_reg        <= b;
                        mul_signed_reg <= (op == 3'd1);
                        cnt_reg        <= CW'(MUL_LAT - 1);
                        busy_reg       <= 1'b1;
                        state_reg      <= MUL;
                    end else if (is_div) begin
                        if (b != 32'd0) begin
                            quo_reg   <= a_abs;
                            opb_reg   <= b_abs;
                            rem_reg   <= '0;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            cnt_reg   <= CW'(DIV_ITER - 1);
                            busy_reg  <= 1'b1;
                            state_reg <= DIV;
                        end else begin
                            // Divide by zero: fixed result, no iterations.
                            hi_reg    <= a;
                            lo_reg    <= 32'hFFFF_FFFF;
                            state_reg <= DONE;
                        end
                    end else if (valid && op == 3'd5) begin
                        hi_reg <= a;
                    end else if (valid && op == 3'd6) begin
                        lo_reg <= a;
                    end
                end

                MUL: begin
                    if (cnt_reg == '0) begin
                        hi_reg    <= product[63:32];
                        lo_reg    <= product[31:0];
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                DIV: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    if (cnt_reg == '0) begin
                        hi_reg    <= rem_fin;
                        lo_reg    <= quo_fin;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                DONE: begin
                    // The held instruction retires this cycle; its op is ignored.
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl - self-checking bench for mdu_ctrl.
// Table-driven directed vectors, hand sequences for flush/reset corners, and
// randomized operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    // Reference HI/LO contents.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tbl[9];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural result of one MDU instruction from plain arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output int cyc);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        eh  = 32'd0;
        el  = 32'd0;
        cyc = 0;
        case (o)
            3'd1: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; cyc = 1 + MUL_LAT; end
            3'd2: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; cyc = 1 + MUL_LAT; end
            3'd3, 3'd4: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF; cyc = 1;
                end else if (o == 3'd3) begin
                    eh = 32'(sx % sy); el = 32'(sx / sy); cyc = 1 + DIV_ITER;
                end else begin
                    eh = x % y; el = x / y; cyc = 1 + DIV_ITER;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue a mul/div, hold it while stalled, check at the DONE cycle.
    // valid/op stay asserted through DONE so a restart there would be caught.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input int ecyc, input string tag);
        int n;
        @(negedge clk);
        valid = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1 && ecyc > 1) check32({tag, " busy_mid"}, {31'd0, busy}, 32'd1);
        end
        check32({tag, " stall_cycles"}, 32'(n), 32'(ecyc));
        check32({tag, " hi"}, hi, eh);
        check32({tag, " lo"}, lo, el);
        check32({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h stall_cycles=%0d", tag, o, x, y, hi, lo, n);
        m_hi = eh;
        m_lo = el;
    endtask

    // Single-cycle MTHI/MTLO.
    task automatic mt_op(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk);
        valid = 1'b1; op = o; a = x; flush = 1'b0;
        #1;
        check32("mt stall", {31'd0, stall}, 32'd0);
        if (o == 3'd5) m_hi = x; else m_lo = x;
        @(negedge clk);
        check32("mt hi", hi, m_hi);
        check32("mt lo", lo, m_lo);
        $display("txn mt op=%0d a=%h -> hi=%h lo=%h", o, x, hi, lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        int          ec;
        int          r;

        tbl[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 3};
        tbl[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 3};
        tbl[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        tbl[3] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        33};
        tbl[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        tbl[5] = '{3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
        tbl[6] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        tbl[7] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         3};
        tbl[8] = '{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};

        // Reset with a divide request presented: stall must stay low.
        rst = 1'b1; valid = 1'b1; op = 3'd3; a = 32'd9; b = 32'd1; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check32("reset stall", {31'd0, stall}, 32'd0);
        check32("reset busy", {31'd0, busy}, 32'd0);
        check32("reset hi", hi, 32'd0);
        check32("reset lo", lo, 32'd0);
        rst = 1'b0; valid = 1'b0; op = 3'd0;

        mt_op(3'd5, 32'h1234_5678);
        mt_op(3'd6, 32'hDEAD_BEEF);

        // Directed vectors, issued back to back (the next one starts the
        // cycle after DONE).
        for (int i = 0; i < 9; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].cyc, $sformatf("vec%0d", i));

        // Flush during a DIVU: HI/LO keep their old values.
        mt_op(3'd5, 32'h11);
        mt_op(3'd6, 32'h11);
        @(negedge clk);
        valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        #1;
        check32("divu accept stall", {31'd0, stall}, 32'd1);
        repeat (10) @(negedge clk);
        flush = 1'b1; valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check32("flush stall", {31'd0, stall}, 32'd0);
        check32("flush busy", {31'd0, busy}, 32'd0);
        check32("flush hi", hi, 32'h11);
        check32("flush lo", lo, 32'h11);
        $display("txn flush-divu -> hi=%h lo=%h busy=%0d", hi, lo, busy);

        // Flush with MTHI suppresses the write.
        @(negedge clk);
        valid = 1'b1; op = 3'd5; a = 32'hABCD_0000; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        check32("flush mthi hi", hi, 32'h11);
        $display("txn flush-mthi -> hi=%h", hi);

        // Flush with a MULT request: not accepted.
        @(negedge clk);
        valid = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4; flush = 1'b1;
        #1;
        check32("flush mult stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        #1;
        check32("flush mult busy", {31'd0, busy}, 32'd0);
        check32("flush mult stall2", {31'd0, stall}, 32'd0);
        check32("flush mult lo", lo, 32'h11);
        $display("txn flush-mult -> busy=%0d lo=%h", busy, lo);

        // Randomized mix against the reference model.
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: rb = $urandom;
            endcase
            if (r < 8) begin
                ro = 3'(1 + (r % 4));
                model(ro, ra, rb, eh, el, ec);
                run_op(ro, ra, rb, eh, el, ec, $sformatf("rnd%0d", i));
            end else begin
                mt_op((r == 8) ? 3'd5 : 3'd6, ra);
            end
        end

        // Asynchronous reset in the middle of a MULT.
        mt_op(3'd5, 32'hCAFE_0001);
        @(negedge clk);
        valid = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check32("rst mid hi", hi, 32'd0);
        check32("rst mid lo", lo, 32'd0);
        check32("rst mid busy", {31'd0, busy}, 32'd0);
        check32("rst mid stall", {31'd0, stall}, 32'd0);
        $display("txn rst-mid-mult -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; op = 3'd0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
